// File: rtl/axis_peak_pkg.sv
// Shared types and constants for the AXI-stream peak capture block.
// PEAK_CAPTURE_TIMESTAMP_EN widens tuser by a trigger timestamp.
package axis_peak_pkg;

  localparam int unsigned TS_WIDTH    = 32;
  localparam int unsigned DET_LATENCY = 3;

`ifdef PEAK_CAPTURE_TIMESTAMP_EN
  localparam int unsigned USER_TS_W = TS_WIDTH;
`else
  localparam int unsigned USER_TS_W = 0;
`endif

  typedef enum logic [1:0] {
    ST_FILL,
    ST_ARMED,
    ST_POST,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/axis_peak_capture_detect.sv
// Per-channel peak detector: boxcar of preceding samples, scaled threshold, strict compare.
// Three accept-enabled stages; peak_o refers to the sample accepted DET_LATENCY accepts earlier.
module peak_chan_detect
  import axis_peak_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH = 32,
  parameter int unsigned AVG_POWER     = 4,
  parameter int unsigned SHIFT_WIDTH   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [CHANNEL_WIDTH-1:0] abs_i,
  input  logic [SHIFT_WIDTH-1:0]   shift_i,
  output logic                     peak_o
);

  localparam int unsigned WinLen = 2 ** AVG_POWER;
  localparam int unsigned SumW   = CHANNEL_WIDTH + AVG_POWER;
  localparam int unsigned ThrW   = CHANNEL_WIDTH + 2 ** SHIFT_WIDTH;

  logic [CHANNEL_WIDTH-1:0] win_q [WinLen];
  logic [SumW-1:0]          sum_q, sum_d;
  logic [CHANNEL_WIDTH-1:0] abs1_q, avg1_q, abs2_q;
  logic [ThrW-1:0]          thr2_q, avg_inc, thr_d;
  logic                     peak3_q;

  assign sum_d   = sum_q + SumW'(abs_i) - SumW'(win_q[WinLen-1]);
  // Full-width threshold so large shifts never wrap.
  assign avg_inc = ThrW'(avg1_q) + ThrW'(1);
  assign thr_d   = avg_inc << shift_i;
  assign peak_o  = peak3_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(WinLen); i++) win_q[i] <= '0;
      sum_q   <= '0;
      abs1_q  <= '0;
      avg1_q  <= '0;
      abs2_q  <= '0;
      thr2_q  <= '0;
      peak3_q <= 1'b0;
    end else if (en_i) begin
      win_q[0] <= abs_i;
      for (int i = 1; i < int'(WinLen); i++) win_q[i] <= win_q[i-1];
      sum_q   <= sum_d;
      // Average of the window before this sample; the candidate itself is excluded.
      abs1_q  <= abs_i;
      avg1_q  <= sum_q[SumW-1:AVG_POWER];
      abs2_q  <= abs1_q;
      thr2_q  <= thr_d;
      peak3_q <= ThrW'(abs2_q) > thr2_q;
    end
  end

endmodule

// File: rtl/axis_peak_capture.sv
// Multi-channel peak trigger with pre/post-trigger burst capture from a ring buffer.
// Define PEAK_CAPTURE_TIMESTAMP_EN to append the trigger-sample accept count to tuser.
module axis_peak_capture
  import axis_peak_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned CHANNEL_WIDTH = 32,
  parameter int unsigned BURST_LENGTH  = 32,
  parameter int unsigned PRE_TRIGGER   = 8,
  parameter int unsigned AVG_POWER     = 4,
  parameter int unsigned SHIFT_WIDTH   = 4,
  parameter int unsigned HOLD_WIDTH    = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  cfg_enable_i,
  input  logic [NUM_CHANNELS-1:0]               cfg_chan_mask_i,
  input  logic [SHIFT_WIDTH-1:0]                cfg_thresh_shift_i,
  input  logic [HOLD_WIDTH-1:0]                 cfg_holdoff_i,
  input  logic                                  s_axis_tvalid_i,
  output logic                                  s_axis_tready_o,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] s_axis_tdata_i,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] s_axis_tdata_abs_i,
  output logic                                  m_axis_tvalid_o,
  input  logic                                  m_axis_tready_i,
  output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] m_axis_tdata_o,
  output logic                                  m_axis_tlast_o,
  output logic [NUM_CHANNELS+USER_TS_W-1:0]     m_axis_tuser_o
);

  localparam int unsigned DataW = NUM_CHANNELS * CHANNEL_WIDTH;
  localparam int unsigned PtrW  = $clog2(BURST_LENGTH);
  localparam int unsigned CntW  = PtrW + 1;

  state_e                  state_q;
  logic [HOLD_WIDTH-1:0]   fill_cnt_q, holdoff_q;
  logic [PtrW-1:0]         post_cnt_q, wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         issue_cnt_q;
  logic [NUM_CHANNELS-1:0] trig_mask_q, peak;
  logic                    any_peak_q, s_tready_q;
  logic                    a_vld_q, a_last_q, m_tvalid_q, m_tlast_q;
  logic [DataW-1:0]        m_tdata_q, rd_data_q;
  logic [DataW-1:0]        dly_q [DET_LATENCY];
  logic [DataW-1:0]        mem_q [BURST_LENGTH];

  logic accept, any_peak, trigger, fill_done, out_ready, a_ready, rd_en, last_hs;

  for (genvar ch = 0; ch < int'(NUM_CHANNELS); ch++) begin : g_det
    peak_chan_detect #(
      .CHANNEL_WIDTH (CHANNEL_WIDTH),
      .AVG_POWER     (AVG_POWER),
      .SHIFT_WIDTH   (SHIFT_WIDTH)
    ) u_det (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (accept),
      .abs_i   (s_axis_tdata_abs_i[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
      .shift_i (cfg_thresh_shift_i),
      .peak_o  (peak[ch])
    );
  end

  assign accept    = s_axis_tvalid_i & s_tready_q;
  assign any_peak  = |(peak & cfg_chan_mask_i);
  assign trigger   = accept & (state_q == ST_ARMED) & cfg_enable_i & any_peak & ~any_peak_q;
  assign fill_done = (fill_cnt_q >= HOLD_WIDTH'(PRE_TRIGGER)) && (fill_cnt_q >= holdoff_q);
  assign out_ready = ~m_tvalid_q | m_axis_tready_i;
  assign a_ready   = ~a_vld_q | out_ready;
  assign rd_en     = (state_q == ST_DRAIN) & (issue_cnt_q < CntW'(BURST_LENGTH)) & a_ready;
  assign last_hs   = m_tvalid_q & m_axis_tready_i & m_tlast_q;

  assign s_axis_tready_o = s_tready_q;
  assign m_axis_tvalid_o = m_tvalid_q;
  assign m_axis_tdata_o  = m_tdata_q;
  assign m_axis_tlast_o  = m_tlast_q;

  // Sample data delayed to line up with the detector output, so trig_ptr holds the trigger sample.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DET_LATENCY); i++) dly_q[i] <= '0;
    end else if (accept) begin
      dly_q[0] <= s_axis_tdata_i;
      for (int i = 1; i < int'(DET_LATENCY); i++) dly_q[i] <= dly_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem_q[wr_ptr_q] <= dly_q[DET_LATENCY-1];
    if (rd_en)  rd_data_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_FILL;
      fill_cnt_q  <= '0;
      holdoff_q   <= '0;
      post_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      issue_cnt_q <= '0;
      trig_mask_q <= '0;
      any_peak_q  <= 1'b0;
      s_tready_q  <= 1'b1;
      a_vld_q     <= 1'b0;
      a_last_q    <= 1'b0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tdata_q   <= '0;
    end else begin
      if (accept) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        any_peak_q <= any_peak;
      end

      unique case (state_q)
        ST_FILL: begin
          if (accept && !fill_done) fill_cnt_q <= fill_cnt_q + 1'b1;
          if (fill_done) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (trigger) begin
            trig_mask_q <= peak & cfg_chan_mask_i;
            rd_ptr_q    <= wr_ptr_q - PtrW'(PRE_TRIGGER);
            post_cnt_q  <= '0;
            state_q     <= ST_POST;
          end
        end
        ST_POST: begin
          if (accept) begin
            if (post_cnt_q == PtrW'(BURST_LENGTH - PRE_TRIGGER - 2)) begin
              state_q     <= ST_DRAIN;
              s_tready_q  <= 1'b0;
              issue_cnt_q <= '0;
            end else begin
              post_cnt_q <= post_cnt_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (rd_en) begin
            rd_ptr_q    <= rd_ptr_q + 1'b1;
            issue_cnt_q <= issue_cnt_q + 1'b1;
          end
          if (last_hs) begin
            state_q    <= ST_FILL;
            fill_cnt_q <= '0;
            holdoff_q  <= cfg_holdoff_i;
            s_tready_q <= 1'b1;
          end
        end
        default: state_q <= ST_FILL;
      endcase

      // Read-data stage feeding the output register; both hold while the sink stalls.
      if (rd_en) begin
        a_vld_q  <= 1'b1;
        a_last_q <= (issue_cnt_q == CntW'(BURST_LENGTH - 1));
      end else if (out_ready) begin
        a_vld_q <= 1'b0;
      end

      if (out_ready) begin
        m_tvalid_q <= a_vld_q;
        m_tlast_q  <= a_vld_q & a_last_q;
        if (a_vld_q) m_tdata_q <= rd_data_q;
      end
    end
  end

`ifdef PEAK_CAPTURE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_q, ts_trig_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_cnt_q  <= '0;
      ts_trig_q <= '0;
    end else begin
      if (accept)  ts_cnt_q  <= ts_cnt_q + 1'b1;
      if (trigger) ts_trig_q <= ts_cnt_q - TS_WIDTH'(DET_LATENCY);
    end
  end

  assign m_axis_tuser_o = {ts_trig_q, trig_mask_q};
`else
  assign m_axis_tuser_o = trig_mask_q;
`endif

endmodule

// File: tb/tb_axis_peak_capture.sv
// Scoreboard bench for axis_peak_capture: bursts, masking, threshold edge, stall, holdoff, reset.
module tb_axis_peak_capture;
  import axis_peak_pkg::*;

  localparam int NC  = 4;
  localparam int CW  = 32;
  localparam int BL  = 32;
  localparam int PRE = 8;
  localparam int DW  = NC * CW;
  localparam int UW  = NC + USER_TS_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_enable;
  logic [NC-1:0] cfg_chan_mask;
  logic [3:0]    cfg_thresh_shift;
  logic [15:0]   cfg_holdoff;
  logic          s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] s_tdata, s_tabs, m_tdata;
  logic [UW-1:0] m_tuser;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] hist[$];
  int unsigned   seq = 0;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  axis_peak_capture dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .cfg_enable_i       (cfg_enable),
    .cfg_chan_mask_i    (cfg_chan_mask),
    .cfg_thresh_shift_i (cfg_thresh_shift),
    .cfg_holdoff_i      (cfg_holdoff),
    .s_axis_tvalid_i    (s_tvalid),
    .s_axis_tready_o    (s_tready),
    .s_axis_tdata_i     (s_tdata),
    .s_axis_tdata_abs_i (s_tabs),
    .m_axis_tvalid_o    (m_tvalid),
    .m_axis_tready_i    (m_tready),
    .m_axis_tdata_o     (m_tdata),
    .m_axis_tlast_o     (m_tlast),
    .m_axis_tuser_o     (m_tuser)
  );

  // One sample; channel ch gets magnitude val, the others 10 (ch < 0 means all flat).
  task automatic send_one(input int ch, input int unsigned val);
    logic [DW-1:0] d;
    int w;
    for (int c = 0; c < NC; c++) begin
      d[c*CW +: CW]      = {8'(c), 24'(seq)};
      s_tabs[c*CW +: CW] = (c == ch) ? CW'(val) : CW'(10);
    end
    seq++;
    s_tdata  = d;
    s_tvalid = 1'b1;
    w = 0;
    while (s_tready !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (s_tready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_tready=%b, required 1 within 300 cycles", s_tready);
    end else begin
      @(negedge clk);
      hist.push_back(d);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic flat(input int n);
    for (int i = 0; i < n; i++) send_one(-1, 0);
  endtask

  // Spike after a settled window, then enough samples to finish POST; queue the expected burst.
  task automatic arm_burst(input int ch, input int unsigned val, input logic [NC-1:0] exp_mask);
    beat_t e;
    int t;
    flat(20);
    t = hist.size();
    send_one(ch, val);
    flat(26);
    for (int i = t - PRE; i < t - PRE + BL; i++) begin
      e.data = hist[i];
      e.last = (i == t - PRE + BL - 1);
      e.user = UW'({TS_WIDTH'(t), exp_mask});
      exp_q.push_back(e);
    end
  endtask

  task automatic collect(input string nm, input int nbeats, input int stall_beat,
                         input int stall_cyc);
    beat_t e;
    int beat = 0;
    int stalled = 0;
    int cyc = 0;
    logic rdy_ok = 1'b1;
    while (beat < nbeats && cyc < 2000) begin
      m_tready = !(beat == stall_beat && stalled < stall_cyc);
      if (m_tvalid === 1'b1) begin
        if (s_tready !== 1'b0) rdy_ok = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s_unexpected_beat: got data=%h, required no beat", nm, m_tdata);
          beat++;
        end else if (m_tready) begin
          e = exp_q.pop_front();
          if (m_tdata !== e.data || m_tlast !== e.last || m_tuser !== e.user) begin
            errors++;
            $display("FAIL %s_beat%0d: got data=%h last=%b user=%h, required data=%h last=%b user=%h",
                     nm, beat, m_tdata, m_tlast, m_tuser, e.data, e.last, e.user);
          end
          beat++;
        end else begin
          stalled++;
          if (m_tdata !== exp_q[0].data || m_tlast !== exp_q[0].last) begin
            errors++;
            $display("FAIL %s_stall%0d: got data=%h last=%b, required data=%h last=%b",
                     nm, stalled, m_tdata, m_tlast, exp_q[0].data, exp_q[0].last);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    m_tready = 1'b0;
    checks++;
    if (beat != nbeats) begin
      errors++;
      $display("FAIL %s_beats: got %0d beats, required %0d", nm, beat, nbeats);
    end
    checks++;
    if (!rdy_ok) begin
      errors++;
      $display("FAIL %s_s_tready: got 1 during drain, required 0", nm);
    end
  endtask

  task automatic check_idle(input string nm);
    repeat (3) @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_idle: got tvalid=%b s_tready=%b pending=%0d, required 0/1/0",
               nm, m_tvalid, s_tready, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_last: got %b/%b, required 0/0", m_tvalid, m_tlast);
    end
    checks++;
    if (m_tuser !== '0) begin
      errors++;
      $display("FAIL reset_tuser: got %h, required 0", m_tuser);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_tready: got %b, required 1", s_tready);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    arm_burst(2, 200, 4'b0100);
    collect("basic", BL, -1, 0);
    check_idle("basic");
  endtask

  task automatic test_mask();
    cfg_chan_mask = 4'b1101;
    flat(20);
    send_one(1, 200);
    flat(30);
    check_idle("mask_off");
    cfg_chan_mask = 4'hF;
    arm_burst(1, 200, 4'b0010);
    collect("mask_on", BL, -1, 0);
    check_idle("mask_on");
  endtask

  task automatic test_threshold();
    flat(20);
    send_one(0, 88);
    flat(30);
    check_idle("thresh_88");
    arm_burst(0, 89, 4'b0001);
    collect("thresh_89", BL, -1, 0);
    check_idle("thresh_89");
  endtask

  task automatic test_backpressure();
    arm_burst(3, 500, 4'b1000);
    cfg_holdoff = 16'd100;
    collect("stall", BL, 3, 5);
    check_idle("stall");
  endtask

  task automatic test_holdoff();
    flat(49);
    send_one(2, 200);
    flat(80);
    check_idle("holdoff_early");
    arm_burst(2, 200, 4'b0100);
    cfg_holdoff = 16'd0;
    collect("holdoff_late", BL, -1, 0);
    check_idle("holdoff_late");
  endtask

  task automatic test_reset_midburst();
    arm_burst(0, 300, 4'b0001);
    collect("rst_mid", 10, -1, 0);
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_beat10: got tvalid=%b, required 1", m_tvalid);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || s_tready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_outputs: got tvalid=%b tlast=%b s_tready=%b, required 0/0/1",
               m_tvalid, m_tlast, s_tready);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    hist.delete();
    m_tready = 1'b1;
    check_idle("rst_mid_after");
    m_tready = 1'b0;
  endtask

  // Spike lands on accept index 1000 after reset.
  task automatic test_timestamp();
    flat(980);
    arm_burst(2, 200, 4'b0100);
    collect("timestamp", BL, -1, 0);
    check_idle("timestamp");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    cfg_enable       = 1'b1;
    cfg_chan_mask    = 4'hF;
    cfg_thresh_shift = 4'd3;
    cfg_holdoff      = 16'd0;
    s_tvalid         = 1'b0;
    s_tdata          = '0;
    s_tabs           = '0;
    m_tready         = 1'b0;
    test_reset();
    test_basic();
    test_mask();
    test_threshold();
    test_backpressure();
    test_holdoff();
    test_reset_midburst();
    test_timestamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
